// File: rtl/row_scan_pkg.sv
// Shared LED-panel definitions: scan state encoding and address-width helper.
package row_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    // Row address width for n rows, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/row_scan_if.sv
// Row-scan control bundle between the panel sequencer and its column shifter/panel.
interface row_scan_if
#(
    parameter int ROWS    = 16,
    parameter int DWELL_W = 8
);
    import row_scan_pkg::*;

    localparam int ROW_W = clog2_min1(ROWS);

    logic               en;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic               shift_done;
    logic [ROW_W-1:0]   row;
    logic               oe_n;
    logic               lat;
    logic               shift_start;
    logic               frame_start;

    modport master (
        output en, dir, dwell, shift_done,
        input  row, oe_n, lat, shift_start, frame_start
    );

    modport slave (
        input  en, dir, dwell, shift_done,
        output row, oe_n, lat, shift_start, frame_start
    );

endinterface

// File: rtl/row_scan_dwell_timer.sv
// Per-row display timer: down-counter loaded on DISPLAY entry, expires on its last cycle.
module row_scan_dwell_timer
#(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // cnt holds the cycles still owed including the current one.
    assign expired = (cnt <= W'(1));

endmodule

// File: rtl/row_scan.sv
// LED panel row sequencer: blanks, latches and displays one row at a time.
//   state   | meaning
//   IDLE    | parked, panel blanked
//   PRELOAD | first row's column data being shifted
//   BLANK   | one-cycle blank before latching
//   LATCH   | latch strobe, row address advanced
//   DISPLAY | row lit for dwell cycles and until the next row is shifted
module row_scan
    import row_scan_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int DWELL_W = 8
) (
    input  logic      clk_in,
    input  logic      rst_n,
    row_scan_if.slave bus
);
    localparam int               ROW_W    = clog2_min1(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    scan_state_t        state, state_nx;
    logic [ROW_W-1:0]   row_q, nxt_q, nxt_adv;
    logic               oe_n_q, lat_q, shift_start_q, frame_start_q;
    logic               done_q;
    logic [DWELL_W-1:0] dwell_eff;
    logic               expired;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.en) state_nx = ST_PRELOAD;
            ST_PRELOAD: if (bus.shift_done) state_nx = ST_BLANK;
            ST_BLANK:   state_nx = ST_LATCH;
            ST_LATCH:   state_nx = ST_DISPLAY;
            ST_DISPLAY: if (expired && (done_q || bus.shift_done))
                            state_nx = bus.en ? ST_BLANK : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_adv = nxt_q;
        if (!bus.dir) nxt_adv = (nxt_q == LAST_ROW) ? '0 : nxt_q + 1'b1;
        else          nxt_adv = (nxt_q == '0) ? LAST_ROW : nxt_q - 1'b1;
    end

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= '0;
            nxt_q         <= '0;
            oe_n_q        <= 1'b1;
            lat_q         <= 1'b0;
            shift_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            oe_n_q        <= (state_nx != ST_DISPLAY);
            lat_q         <= (state_nx == ST_LATCH);
            shift_start_q <= ((state_nx == ST_PRELOAD) && (state != ST_PRELOAD)) ||
                             ((state_nx == ST_DISPLAY) && (state != ST_DISPLAY));
            frame_start_q <= (state == ST_LATCH) && (nxt_q == '0);
            if (state == ST_LATCH) begin
                row_q  <= nxt_q;
                nxt_q  <= nxt_adv;
                done_q <= 1'b0;
            end else if ((state == ST_DISPLAY) && bus.shift_done) begin
                done_q <= 1'b1;
            end
        end
    end

    row_scan_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (state == ST_LATCH),
        .load_val (dwell_eff),
        .count    (state == ST_DISPLAY),
        .expired  (expired)
    );

    assign bus.row         = row_q;
    assign bus.oe_n        = oe_n_q;
    assign bus.lat         = lat_q;
    assign bus.shift_start = shift_start_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_row_scan.sv
// Bench for row_scan: a 16-row and a 12-row instance checked against a row-level display model.
module tb_row_scan;
    import row_scan_pkg::*;

    typedef struct {
        int row;
        bit frame;
        int len;
    } exp_t;

    localparam int LIMIT = 3000;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_n_c  [2];
    logic       en_c     [2];
    logic       dir_c    [2];
    logic [7:0] dwell_c  [2];
    logic       sd_pulse [2];
    int         sd_delay [2];
    int         sd_cnt   [2];

    int   checks   = 0;
    int   failures = 0;
    int   rows_of  [2] = '{16, 12};
    int   m_nxt    [2];
    exp_t q0[$];
    exp_t q1[$];

    bit   in_run   [2];
    bit   prev_oe  [2];
    bit   prev2_oe [2];
    bit   prev_lat [2];
    int   run_len  [2];
    exp_t cur      [2];
    int   frames   [2];
    int   low_cyc  [2];
    int   rows_seen[2];

    row_scan_if #(.ROWS(16), .DWELL_W(8)) b16 ();
    row_scan_if #(.ROWS(12), .DWELL_W(8)) b12 ();

    row_scan #(.ROWS(16), .DWELL_W(8)) dut16 (.clk_in(clk_in), .rst_n(rst_n_c[0]), .bus(b16.slave));
    row_scan #(.ROWS(12), .DWELL_W(8)) dut12 (.clk_in(clk_in), .rst_n(rst_n_c[1]), .bus(b12.slave));

    assign b16.en    = en_c[0];
    assign b16.dir   = dir_c[0];
    assign b16.dwell = dwell_c[0];
    assign b12.en    = en_c[1];
    assign b12.dir   = dir_c[1];
    assign b12.dwell = dwell_c[1];
    // A zero delay models a shifter that answers in the same cycle it is asked.
    assign b16.shift_done = (sd_delay[0] == 0) ? b16.shift_start : sd_pulse[0];
    assign b12.shift_done = (sd_delay[1] == 0) ? b12.shift_start : sd_pulse[1];

    task automatic check_eq(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s [dut%0d]: got %0d expected %0d", name, i, act, exp);
        end
    endtask

    function automatic int step_row(input int r, input bit d, input int rows);
        return d ? (r + rows - 1) % rows : (r + 1) % rows;
    endfunction

    // Lit time: at least the dwell (minimum one), and long enough to see the shifter's reply.
    function automatic int exp_len(input int dw, input int dly);
        int e;
        e = (dw < 1) ? 1 : dw;
        if (dly + 1 > e) e = dly + 1;
        return e;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_rows(input int i, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.row   = m_nxt[i];
            e.frame = (m_nxt[i] == 0);
            e.len   = exp_len(int'(dwell_c[i]), sd_delay[i]);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_nxt[i] = step_row(m_nxt[i], dir_c[i], rows_of[i]);
        end
    endtask

    task automatic wait_drained(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk_in); #1;
            n++;
        end while ((qsize(i) != 0 || !in_run[i]) && n < LIMIT);
        check_eq("drain_in_time", i, int'(n < LIMIT), 1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk_in); #1;
            n++;
        end while ((qsize(i) != 0 || in_run[i]) && n < LIMIT);
        check_eq("idle_in_time", i, int'(n < LIMIT), 1);
        repeat (4) @(negedge clk_in);
        #1;
    endtask

    // Column shifter: one done pulse sd_delay cycles after each shift_start.
    initial begin
        for (int i = 0; i < 2; i++) begin
            sd_pulse[i] = 1'b0;
            sd_cnt[i]   = 0;
        end
        forever begin
            @(negedge clk_in);
            for (int i = 0; i < 2; i++) begin
                logic ss;
                ss = (i == 0) ? b16.shift_start : b12.shift_start;
                sd_pulse[i] = 1'b0;
                if (rst_n_c[i] !== 1'b1) begin
                    sd_cnt[i] = 0;
                end else begin
                    if (sd_cnt[i] > 0) begin
                        sd_cnt[i]--;
                        if (sd_cnt[i] == 0) sd_pulse[i] = 1'b1;
                    end
                    if (ss === 1'b1 && sd_delay[i] > 0) sd_cnt[i] = sd_delay[i];
                end
            end
        end
    end

    // Compare process: every cycle, both instances against the expected row stream.
    initial begin
        for (int i = 0; i < 2; i++) begin
            in_run[i] = 0; prev_oe[i] = 1; prev2_oe[i] = 1; prev_lat[i] = 0;
            run_len[i] = 0; frames[i] = 0; low_cyc[i] = 0; rows_seen[i] = 0;
        end
        forever begin
            @(negedge clk_in);
            for (int i = 0; i < 2; i++) begin
                logic [3:0] lrow;
                logic       loe, llat, lss, lfs;
                lrow = (i == 0) ? b16.row         : b12.row;
                loe  = (i == 0) ? b16.oe_n        : b12.oe_n;
                llat = (i == 0) ? b16.lat         : b12.lat;
                lss  = (i == 0) ? b16.shift_start : b12.shift_start;
                lfs  = (i == 0) ? b16.frame_start : b12.frame_start;
                if (rst_n_c[i] !== 1'b1) begin
                    check_eq("rst_row", i, int'(lrow), 0);
                    check_eq("rst_oe_n", i, int'(loe), 1);
                    check_eq("rst_lat", i, int'(llat), 0);
                    check_eq("rst_shift_start", i, int'(lss), 0);
                    check_eq("rst_frame_start", i, int'(lfs), 0);
                    in_run[i] = 0; prev_oe[i] = 1; prev2_oe[i] = 1; prev_lat[i] = 0;
                end else begin
                    check_eq("row_in_range", i, int'(int'(lrow) < rows_of[i]), 1);
                    if (llat) begin
                        check_eq("lat_while_blank", i, int'(loe), 1);
                        check_eq("lat_one_cycle", i, int'(prev_lat[i]), 0);
                    end
                    if (lfs) check_eq("frame_on_row_start", i, int'(!loe && prev_oe[i]), 1);
                    if (lfs) frames[i]++;
                    if (!loe) low_cyc[i]++;
                    if (!loe && prev_oe[i]) begin
                        if (qsize(i) == 0) begin
                            check_eq("unexpected_row_lit", i, int'(lrow), -1);
                            cur[i].row = int'(lrow); cur[i].frame = lfs; cur[i].len = 0;
                        end else begin
                            cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                        end
                        rows_seen[i]++;
                        check_eq("row_value", i, int'(lrow), cur[i].row);
                        check_eq("frame_start", i, int'(lfs), int'(cur[i].frame));
                        check_eq("shift_start_at_display", i, int'(lss), 1);
                        check_eq("latch_before_display", i, int'(prev_lat[i]), 1);
                        check_eq("two_blank_cycles", i, int'(prev2_oe[i]), 1);
                        in_run[i]  = 1;
                        run_len[i] = 1;
                    end else if (!loe) begin
                        run_len[i]++;
                        check_eq("row_stable", i, int'(lrow), cur[i].row);
                        check_eq("shift_start_once", i, int'(lss), 0);
                    end else if (!prev_oe[i]) begin
                        check_eq("display_cycles", i, run_len[i], cur[i].len);
                        in_run[i] = 0;
                    end
                    prev2_oe[i] = prev_oe[i];
                    prev_oe[i]  = loe;
                    prev_lat[i] = llat;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, l0, r1, k;
        for (int i = 0; i < 2; i++) begin
            rst_n_c[i] = 1'b0; en_c[i] = 1'b0; dir_c[i] = 1'b0;
            dwell_c[i] = 8'd4; sd_delay[i] = 2; m_nxt[i] = 0;
        end

        // Hand-computed pins on the model itself.
        check_eq("model_len_dwell4", 0, exp_len(4, 2), 4);
        check_eq("model_len_late_done", 0, exp_len(3, 9), 10);
        check_eq("model_len_dwell0", 0, exp_len(0, 0), 1);
        check_eq("model_wrap_up", 0, step_row(15, 1'b0, 16), 0);
        check_eq("model_wrap_down", 1, step_row(0, 1'b1, 12), 11);

        repeat (3) @(negedge clk_in);
        #1;
        rst_n_c[0] = 1'b1;
        rst_n_c[1] = 1'b1;
        repeat (4) @(negedge clk_in);
        #1;
        check_eq("idle_oe_n", 0, int'(b16.oe_n), 1);
        check_eq("idle_row", 0, int'(b16.row), 0);

        // 16 rows increasing and 12 rows decreasing, side by side.
        fork
            begin
                dwell_c[0] = 8'd4; sd_delay[0] = 2; dir_c[0] = 1'b0;
                f0 = frames[0]; l0 = low_cyc[0];
                push_rows(0, 17);
                en_c[0] = 1'b1;
                wait_drained(0);
                en_c[0] = 1'b0;
                wait_idle(0);
                check_eq("s16_frames", 0, frames[0] - f0, 2);
                check_eq("s16_low_cycles", 0, low_cyc[0] - l0, 68);
            end
            begin
                dwell_c[1] = 8'd2; sd_delay[1] = 1; dir_c[1] = 1'b1;
                f1 = frames[1]; r1 = rows_seen[1];
                push_rows(1, 14);
                en_c[1] = 1'b1;
                wait_drained(1);
                en_c[1] = 1'b0;
                wait_idle(1);
                check_eq("s12_frames", 1, frames[1] - f1, 2);
                check_eq("s12_rows", 1, rows_seen[1] - r1, 14);
            end
        join

        // Shifter reply long after the dwell: row stays lit until it arrives.
        dwell_c[0] = 8'd3; sd_delay[0] = 9; l0 = low_cyc[0];
        push_rows(0, 2);
        en_c[0] = 1'b1;
        wait_drained(0);
        en_c[0] = 1'b0;
        wait_idle(0);
        check_eq("late_done_low_cycles", 0, low_cyc[0] - l0, 20);

        // Zero dwell with an immediate shifter: one lit cycle per row.
        dwell_c[0] = 8'd0; sd_delay[0] = 0; l0 = low_cyc[0];
        push_rows(0, 4);
        en_c[0] = 1'b1;
        wait_drained(0);
        en_c[0] = 1'b0;
        wait_idle(0);
        check_eq("dwell0_low_cycles", 0, low_cyc[0] - l0, 4);

        // Enable dropped part-way through a row.
        dwell_c[0] = 8'd6; sd_delay[0] = 2;
        push_rows(0, 2);
        en_c[0] = 1'b1;
        wait_drained(0);
        repeat (2) @(negedge clk_in);
        #1;
        en_c[0] = 1'b0;
        wait_idle(0);
        check_eq("parked_oe_n", 0, int'(b16.oe_n), 1);

        // Dwell changed while a row is lit applies from the following row.
        dwell_c[0] = 8'd3; sd_delay[0] = 1;
        push_rows(0, 1);
        en_c[0] = 1'b1;
        wait_drained(0);
        dwell_c[0] = 8'd6;
        push_rows(0, 2);
        wait_drained(0);
        en_c[0] = 1'b0;
        wait_idle(0);

        // Reset while row 7 is lit, then restart from row 0.
        dwell_c[0] = 8'd4; sd_delay[0] = 2;
        k = ((7 - m_nxt[0] + 16) % 16) + 1;
        push_rows(0, k);
        en_c[0] = 1'b1;
        wait_drained(0);
        check_eq("row7_before_reset", 0, int'(b16.row), 7);
        repeat (1) @(negedge clk_in);
        @(posedge clk_in);
        #2;
        rst_n_c[0] = 1'b0;
        #1;
        check_eq("async_rst_oe_n", 0, int'(b16.oe_n), 1);
        check_eq("async_rst_row", 0, int'(b16.row), 0);
        repeat (3) @(negedge clk_in);
        #1;
        m_nxt[0] = 0;
        push_rows(0, 2);
        rst_n_c[0] = 1'b1;
        wait_drained(0);
        en_c[0] = 1'b0;
        wait_idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
